sosu_scan_ctrl: RTL

- Sequencer that sweeps candidate values lo..hi through the combinational prime checker `sosu` (a -> y).
- Streams each prime found over a valid/ready output and counts the primes.
- Sits between a host that issues `start` with a range and the checker, which is instantiated beside it at top level.
- Turns the checker from a bench-driven block into a self-scheduling resource.

---
 rtl/sosu_pkg.sv | 18 +
 rtl/sosu_scan_ctrl_if.sv | 26 ++
 rtl/sosu.sv | 21 ++
 rtl/sosu_scan_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/sosu_pkg.sv
// Shared types and constants for the sosu prime checker and its scan sequencer.
package sosu_pkg;

  localparam int unsigned SOSU_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Count must hold 2^W when every candidate is prime-reported, hence one extra bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/sosu_scan_ctrl_if.sv
// Host command and prime stream bundle for sosu_scan_ctrl.
interface sosu_scan_ctrl_if
  import sosu_pkg::*;
#(
  parameter int unsigned W = SOSU_W
);
  logic             start;
  logic [W-1:0]     lo;
  logic [W-1:0]     hi;
  logic             p_valid;
  logic [W-1:0]     p_data;
  logic             p_ready;
  logic             busy;
  logic             done;
  logic [W:0]       count;

  modport master (
    output start, lo, hi, p_ready,
    input  p_valid, p_data, busy, done, count
  );

  modport slave (
    input  start, lo, hi, p_ready,
    output p_valid, p_data, busy, done, count
  );
endinterface

// File: rtl/sosu.sv
// Combinational prime checker: y=1 when candidate a is prime.
module sosu
  import sosu_pkg::*;
#(
  parameter int unsigned W = SOSU_W
) (
  input  logic [W-1:0] a,
  output logic         y
);

  // Trial division by every smaller value; the loop bound is a constant.
  always_comb begin
    logic [31:0] av;
    av = 32'(a);
    y  = (av >= 32'd2);
    for (int unsigned d = 2; d < (2 ** W); d++) begin
      if ((32'(d) < av) && ((av % 32'(d)) == 32'd0)) y = 1'b0;
    end
  end

endmodule

// File: rtl/sosu_scan_ctrl.sv
// Sweeps lo..hi through the sosu checker and streams primes over valid/ready.
// Optional SOSU_SCAN_SKIP_EVEN_EN: even candidates above 2 are skipped.
module sosu_scan_ctrl
  import sosu_pkg::*;
#(
  parameter int unsigned W = SOSU_W
) (
  input  logic              clk,
  input  logic              rst_n,
  sosu_scan_ctrl_if.slave   bus,
  output logic [W-1:0]      chk_a,
  input  logic              chk_y
);

  localparam int unsigned CW = cnt_w(W);

  state_t          state_q, state_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    chk_a_d;
  logic [W-1:0]    p_data_q, p_data_d;
  logic            p_valid_q, p_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CW-1:0]   count_q, count_d;

  logic [CW-1:0]   first_c, next_c;
  logic            last_c, empty_c;

  // First candidate, successor and end test, all in W+1 bits so hi=2^W-1 never wraps.
  always_comb begin
`ifdef SOSU_SCAN_SKIP_EVEN_EN
    first_c = (!bus.lo[0] && (bus.lo > W'(2))) ? ({1'b0, bus.lo} + CW'(1)) : {1'b0, bus.lo};
    next_c  = {1'b0, chk_a} + ((chk_a < W'(3)) ? CW'(1) : CW'(2));
    last_c  = (next_c > {1'b0, hi_q});
`else
    first_c = {1'b0, bus.lo};
    next_c  = {1'b0, chk_a} + CW'(1);
    last_c  = (chk_a == hi_q);
`endif
    empty_c = (first_c > {1'b0, bus.hi});
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      chk_a     <= '0;
      p_data_q  <= '0;
      p_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      chk_a     <= chk_a_d;
      p_data_q  <= p_data_d;
      p_valid_q <= p_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = empty_c ? DONE : CHECK;
      CHECK:   if (chk_y) state_d = EMIT;
               else if (last_c) state_d = DONE;
      EMIT:    if (bus.p_ready) state_d = last_c ? DONE : CHECK;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; flags follow the state being entered.
  always_comb begin
    hi_d      = hi_q;
    chk_a_d   = chk_a;
    p_data_d  = p_data_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        hi_d    = bus.hi;
        chk_a_d = W'(first_c);
        count_d = '0;
      end
      CHECK: begin
        if (chk_y)        p_data_d = chk_a;
        else if (!last_c) chk_a_d  = W'(next_c);
      end
      EMIT: if (bus.p_ready) begin
        count_d = count_q + CW'(1);
        if (!last_c) chk_a_d = W'(next_c);
      end
      default: ;
    endcase
    p_valid_d = (state_d == EMIT);
    busy_d    = (state_d == CHECK) || (state_d == EMIT);
    done_d    = (state_d == DONE);
  end

  assign bus.p_valid = p_valid_q;
  assign bus.p_data  = p_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.count   = count_q;

endmodule
